// File: rtl/riscv_pkg.sv
// Shared constants, fetch FSM encoding and small helpers for the front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

  // First fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // ADDI x0,x0,0: presented to decode whenever no real instruction is held.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Sequential fetch stride (one 32-bit word).
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch sequencer states:
  //   FETCH_REQ  - no request outstanding, may issue one
  //   FETCH_WAIT - one request accepted, its response will be used
  //   FETCH_DROP - one request accepted, its response will be thrown away
  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// One-entry fetch->decode holding register (valid, instruction, pc).
// Latency: written data visible the cycle after i_wr.
// Backpressure: holds its entry until decode handshakes (o_valid & i_consume) or i_clr.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_wr/i_wr_inst/i_wr_pc  load an accepted fetch response
//   i_clr                 redirect flush (highest priority after reset)
//   i_consume             decode ready; retires the entry when o_valid is set
//   o_valid/o_inst/o_pc   held entry; o_inst is the NOP word while empty
module if_id_buffer
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  logic [31:0] i_wr_inst,
  input  logic [31:0] i_wr_pc,
  input  logic        i_clr,
  input  logic        i_consume,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  // The fetch sequencer only issues a request while this buffer is empty, so
  // a write never meets a still-valid entry; the consume branch is therefore
  // only reachable when no write is pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0000_0000;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_inst  <= i_wr_inst;
      r_pc    <= i_wr_pc;
    end else if (r_valid && i_consume) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requester feeding a one-entry decode buffer.
// Latency: response in cycle N -> id_valid in N+1; next request the cycle after the buffer empties.
// Backpressure: no request is issued while the decode buffer is full or a redirect is active.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr request channel (word-aligned address)
//   imem_rsp_valid, imem_rsp_data   response channel (no backpressure)
//   id_valid/ready, id_inst, id_pc  decode-side handshake
//   br_taken, br_target             redirect from execute
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         w_req_vld;
  logic         w_buf_wr;
  logic         w_buf_vld;

  // ---------------------------------------------------------------------
  // State and pc registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state / pc / request logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_vld   = 1'b0;
    w_buf_wr    = 1'b0;

    unique case (r_state)
      FETCH_REQ: begin
        // A redirect withdraws the request for this cycle; the new pc is
        // presented from the next cycle on. Responses here are stray and ignored.
        w_req_vld = !w_buf_vld && !br_taken;
        if (w_req_vld && imem_req_ready) begin
          w_state_nxt = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_nxt = FETCH_REQ;
          if (!br_taken) begin
            w_buf_wr = 1'b1;
            w_pc_nxt = r_pc + PC_STEP;  // wraps naturally at 2^32
          end
        end else if (br_taken) begin
          // The in-flight response belongs to the old path: wait it out.
          w_state_nxt = FETCH_DROP;
        end
      end

      FETCH_DROP: begin
        // Any response retires the outstanding request, even if another
        // redirect arrives in the same cycle.
        if (imem_rsp_valid) begin
          w_state_nxt = FETCH_REQ;
        end
      end

      default: begin
        w_state_nxt = FETCH_REQ;
      end
    endcase

    // Redirect wins over the sequential increment in every state.
    if (br_taken) begin
      w_pc_nxt = align_word(br_target);
    end
  end

  // Held low while reset is asserted regardless of the current state.
  assign imem_req_valid = w_req_vld && rst_n;
  assign imem_addr      = r_pc;

  // ---------------------------------------------------------------------
  // Decode buffer
  // ---------------------------------------------------------------------
  if_id_buffer #(
    .NOP_INST (NOP_INST)
  ) u_if_id_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (w_buf_wr),
    .i_wr_inst (imem_rsp_data),
    .i_wr_pc   (r_pc),
    .i_clr     (br_taken),
    .i_consume (id_ready),
    .o_valid   (w_buf_vld),
    .o_inst    (id_inst),
    .o_pc      (id_pc)
  );

  assign id_valid = w_buf_vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        br_taken;
  logic [31:0] br_target;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .br_taken       (br_taken),
    .br_target      (br_target)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: next fetch address, whether a request is in flight
  // and whether its response is stale, plus the decode slot contents.
  // ---------------------------------------------------------------------
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_stale;
  bit          m_full;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;

  function automatic bit exp_req();
    return rst_n && !m_busy && !m_full && !br_taken;
  endfunction

  task automatic check_outputs();
    bit rv;
    rv = exp_req();
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, rv});
    if (rv) chk("req_addr", imem_addr, m_pc);
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_full});
    chk("id_inst", id_inst, m_full ? m_inst : 32'h0000_0013);
    if (m_full) chk("id_pc", id_pc, m_ipc);
  endtask

  task automatic model_step();
    bit rv;
    bit rsp;
    rv  = exp_req();
    rsp = imem_rsp_valid && m_busy;
    if (!rst_n) begin
      m_pc = 32'h0; m_busy = 0; m_stale = 0; m_full = 0; m_ipc = 32'h0;
    end else begin
      if (m_full && id_ready) m_full = 0;
      if (br_taken) begin
        m_full = 0;
        if (rsp) begin
          m_busy = 0; m_stale = 0;
        end else if (m_busy) begin
          m_stale = 1;
        end
        m_pc = br_target & 32'hFFFF_FFFC;
      end else if (rsp) begin
        m_busy = 0;
        if (m_stale) begin
          m_stale = 0;
        end else begin
          m_full = 1; m_inst = imem_rsp_data; m_ipc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (rv && imem_req_ready) begin
        m_busy = 1;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Memory environment for the random phase
  // ---------------------------------------------------------------------
  bit          e_pend;
  int          e_cnt;
  logic [31:0] e_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F13;
  endfunction

  task automatic env_pre();
    if (imem_rsp_valid && e_pend) e_pend = 0;
    if (imem_req_valid && imem_req_ready) begin
      e_pend = 1; e_cnt = $urandom_range(1, 3); e_addr = imem_addr;
    end
    if (!rst_n) e_pend = 0;
  endtask

  task automatic drive_random();
    rst_n          = ($urandom_range(0, 199) != 0);
    imem_req_ready = ($urandom_range(0, 3) != 0);
    id_ready       = ($urandom_range(0, 2) != 0);
    br_taken       = ($urandom_range(0, 11) == 0);
    br_target      = $urandom;
    if ($urandom_range(0, 3) == 0) br_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    imem_rsp_valid = 0;
    imem_rsp_data  = $urandom;
    if (e_pend) begin
      e_cnt--;
      if (e_cnt == 0) begin
        imem_rsp_valid = 1; imem_rsp_data = mem_word(e_addr);
      end
    end else begin
      imem_rsp_valid = ($urandom_range(0, 15) == 0);  // stray response
    end
  endtask

  // One clock: compare at the falling edge, advance model, step past the rising edge.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    env_pre();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; imem_req_ready = 1; id_ready = 0; br_taken = 0; br_target = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0;
    m_pc = 0; m_busy = 0; m_stale = 0; m_full = 0; m_inst = 0; m_ipc = 0;
    e_pend = 0; e_cnt = 0; e_addr = 0;
    @(posedge clk); #1;

    // Reset state
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    tick();

    // First fetch and its response
    rst_n = 1; #1;
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 0; #1;
    chk("first_id_valid", {31'd0, id_valid}, 32'd1);
    chk("first_id_inst", id_inst, 32'h0010_0093);
    chk("first_id_pc", id_pc, 32'h0);

    // Decode stall holds everything
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("stall_id_inst", id_inst, 32'h0010_0093);
      tick();
    end
    id_ready = 1;
    tick();
    id_ready = 0; #1;
    chk("after_stall_req", {31'd0, imem_req_valid}, 32'd1);
    chk("after_stall_addr", imem_addr, 32'h4);

    // Redirect while waiting, response two cycles later is dropped
    tick();
    br_taken = 1; br_target = 32'h0000_0103;
    tick();
    br_taken = 0;
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 0; #1;
    chk("drop_id_valid", {31'd0, id_valid}, 32'd0);
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_addr", imem_addr, 32'h0000_0100);

    // Redirect coinciding with the response
    tick();
    imem_rsp_valid = 1; br_taken = 1; br_target = 32'h0000_0200;
    tick();
    imem_rsp_valid = 0; br_taken = 0; #1;
    chk("same_cyc_id_valid", {31'd0, id_valid}, 32'd0);
    chk("same_cyc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("same_cyc_addr", imem_addr, 32'h0000_0200);

    // pc wrap at the top of the address space (target low bits masked)
    br_taken = 1; br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 0; #1;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0513;
    tick();
    imem_rsp_valid = 0; #1;
    chk("top_id_pc", id_pc, 32'hFFFF_FFFC);
    id_ready = 1;
    tick();
    id_ready = 0; #1;
    chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Reset during WAIT, late response afterwards is ignored
    tick();
    rst_n = 0;
    tick();
    #1;
    chk("wait_rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("wait_rst_id_inst", id_inst, 32'h0000_0013);
    chk("wait_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1; imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678; #1;
    chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    tick();
    imem_rsp_valid = 0; #1;
    chk("late_rsp_id_valid", {31'd0, id_valid}, 32'd0);

    // Randomized traffic against the model
    e_pend = 0;
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
